lm70_read_sequencer: RTL and testbench

- Controller for the LM70 SPI temperature datapath. It schedules 16-bit read transactions, either periodically or on demand, and generates CS and SCK.
- It captures the serial word MSB-first and presents it with a one-cycle valid strobe.
- It flags sensor faults.
- It sits between the board pins (uio CS/SCK/SIO) and the downstream latch, conversion and display logic. It replaces the free-running fixed-count sequencing with a parameterised, request-driven controller.

---
 rtl/lm70_read_sequencer_pkg.sv | 22 ++
 rtl/lm70_interval_timer.sv | 45 ++++
 rtl/lm70_read_sequencer.sv | 130 +++++++++++++
 tb/tb_lm70_read_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lm70_read_sequencer_pkg.sv
// Shared types and default timing for the LM70 read sequencer.
package lm70_read_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam int unsigned DefHalfPeriod = 2;
    localparam int unsigned DefCsSetup    = 2;
    localparam int unsigned DefMinGap     = 4;
    localparam int unsigned DefInterval   = 1000;
    localparam int unsigned Nbits         = 16;

    // The LM70 always returns ones in bits [4:2]; their absence means a bad read.
    localparam int unsigned Lm70OnesLsb   = 2;
    localparam int unsigned Lm70OnesWidth = 3;

endpackage

// File: rtl/lm70_interval_timer.sv
// Periodic request timer plus the single-entry pending request flag.
module lm70_interval_timer
    import lm70_read_sequencer_pkg::*;
#(
    parameter int unsigned INTERVAL = DefInterval
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic auto_en,
    input  logic start_req,
    input  logic idle,
    output logic launch,
    output logic req_dropped
);

    localparam int unsigned CntW = $clog2(INTERVAL);

    logic [CntW-1:0] cnt_q;
    logic            pending_q;
    logic            wrap;
    logic            new_req;

    assign wrap    = auto_en && ena && (cnt_q == CntW'(INTERVAL - 1));
    // A manual request on the wrap edge merges with the auto request.
    assign new_req = start_req || wrap;
    assign launch  = idle && ena && (pending_q || new_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            if (!auto_en) begin
                cnt_q <= '0;
            end else if (ena) begin
                cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            end
            pending_q   <= launch ? 1'b0 : (pending_q || new_req);
            req_dropped <= new_req && pending_q && !launch;
        end
    end

endmodule

// File: rtl/lm70_read_sequencer.sv
// LM70 SPI read controller: schedules reads, drives CS/SCK, captures the word MSB-first.
module lm70_read_sequencer
    import lm70_read_sequencer_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = DefHalfPeriod,
    parameter int unsigned CS_SETUP    = DefCsSetup,
    parameter int unsigned MIN_GAP     = DefMinGap,
    parameter int unsigned INTERVAL    = DefInterval,
    parameter int unsigned NBITS       = Nbits
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             auto_en,
    input  logic             start_req,
    input  logic             sio,
    output logic             cs_n,
    output logic             sck,
    output logic [NBITS-1:0] sample,
    output logic             sample_valid,
    output logic             busy,
    output logic             sensor_fault,
    output logic             req_dropped
);

    localparam int unsigned CntMax =
        (HALF_PERIOD > CS_SETUP) ? ((HALF_PERIOD > MIN_GAP) ? HALF_PERIOD : MIN_GAP)
                                 : ((CS_SETUP > MIN_GAP) ? CS_SETUP : MIN_GAP);
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam int unsigned BitW = $clog2(NBITS);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [BitW-1:0]   bit_q;
    logic [NBITS-1:0]  cap_q;
    logic              launch;
    logic              idle;

    function automatic logic word_fault(input logic [NBITS-1:0] w);
        return (&w) || (w[Lm70OnesLsb +: Lm70OnesWidth] != '1);
    endfunction

    assign idle = (state_q == StIdle);

    lm70_interval_timer #(
        .INTERVAL (INTERVAL)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .auto_en     (auto_en),
        .start_req   (start_req),
        .idle        (idle),
        .launch      (launch),
        .req_dropped (req_dropped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            cap_q        <= '0;
            cs_n         <= 1'b1;
            sck          <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        state_q <= StSetup;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StSetup: begin
                    if (cnt_q == CntW'(CS_SETUP - 1)) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q == CntW'(HALF_PERIOD - 1)) begin
                        cnt_q <= '0;
                        if (!sck) begin
                            // Sample on the edge that raises SCK; sensor changes SIO on the fall.
                            sck   <= 1'b1;
                            cap_q <= {cap_q[NBITS-2:0], sio};
                        end else begin
                            sck <= 1'b0;
                            if (bit_q == BitW'(NBITS - 1)) begin
                                state_q <= StHold;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    state_q      <= StGap;
                    cs_n         <= 1'b1;
                    sample       <= cap_q;
                    sample_valid <= 1'b1;
                    sensor_fault <= word_fault(cap_q);
                    cnt_q        <= '0;
                end
                StGap: begin
                    if (cnt_q == CntW'(MIN_GAP - 1)) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lm70_read_sequencer.sv
// Self-checking bench: LM70 sensor model, pin monitor, vector table and corner sequences.
module tb_lm70_read_sequencer;

    localparam int unsigned Interval = 200;
    localparam int unsigned CsLow    = 67;
    localparam int unsigned MinGap   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        auto_en = 1'b0;
    logic        start_req = 1'b0;
    logic        sio = 1'b0;
    logic        cs_n;
    logic        sck;
    logic [15:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        sensor_fault;
    logic        req_dropped;

    lm70_read_sequencer #(
        .INTERVAL (Interval)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .auto_en      (auto_en),
        .start_req    (start_req),
        .sio          (sio),
        .cs_n         (cs_n),
        .sck          (sck),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .sensor_fault (sensor_fault),
        .req_dropped  (req_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor and sensor model state, all updated on the falling clk edge.
    logic [15:0] sensor_word = 16'h0000;
    int   bit_idx = 15;
    logic prev_cs = 1'b1;
    logic prev_sck = 1'b0;
    int   cyc = 0;
    int   cs_falls = 0;
    int   fall_cyc = 0;
    int   low_len = 0;
    int   high_len = 0;
    int   last_low_len = 0;
    int   last_high_len = 0;
    int   sck_rises = 0;
    int   valid_cnt = 0;
    int   dropped_cnt = 0;
    int   busy_low_cnt = 0;
    logic valid_at_rise = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!cs_n) begin
            if (prev_cs) begin
                cs_falls      = cs_falls + 1;
                fall_cyc      = cyc;
                last_high_len = high_len;
                low_len       = 0;
                sck_rises     = 0;
                bit_idx       = 15;
            end
            low_len = low_len + 1;
        end else begin
            if (!prev_cs) begin
                last_low_len  = low_len;
                high_len      = 0;
                valid_at_rise = sample_valid;
            end
            high_len = high_len + 1;
        end
        if (sck && !prev_sck) sck_rises = sck_rises + 1;
        // The LM70 shifts out its next bit after each SCK fall.
        if (!sck && prev_sck && bit_idx > 0) bit_idx = bit_idx - 1;
        sio = sensor_word[bit_idx];
        if (sample_valid) valid_cnt = valid_cnt + 1;
        if (req_dropped) dropped_cnt = dropped_cnt + 1;
        if (!busy) busy_low_cnt = busy_low_cnt + 1;
        prev_cs  = cs_n;
        prev_sck = sck;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic ref_fault(input logic [15:0] w);
        return (w == 16'hFFFF) || (((w >> 2) % 8) != 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        step();
        start_req = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int budget);
        int k = 0;
        while (valid_cnt < target && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic wait_rises(input int f0, input int n, input int budget);
        int k = 0;
        while ((cs_falls == f0 || sck_rises < n) && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic do_read(input string tag, input logic [15:0] word, input logic exp_fault);
        int v0;
        sensor_word = word;
        v0 = valid_cnt;
        pulse_start();
        wait_valid(v0 + 1, 150);
        chk({tag, ".valid"}, 32'(valid_cnt - v0), 32'd1);
        chk({tag, ".sample"}, 32'(sample), 32'(word));
        chk({tag, ".fault"}, 32'(sensor_fault), 32'(exp_fault));
        chk({tag, ".cs_low"}, 32'(last_low_len), 32'(CsLow));
        chk({tag, ".sck_rises"}, 32'(sck_rises), 32'd16);
        chk({tag, ".valid_at_cs_rise"}, 32'(valid_at_rise), 32'd1);
        wait_idle(20);
        chk({tag, ".busy_release"}, 32'(busy), 32'd0);
        step();
        chk({tag, ".valid_once"}, 32'(valid_cnt - v0), 32'd1);
    endtask

    typedef struct packed {
        logic [15:0] word;
        logic        fault;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int f0, v0, d0, b0, t1, t2, t3;
        logic [15:0] w;

        vecs[0] = '{word: 16'h0C9F, fault: 1'b0};
        vecs[1] = '{word: 16'hFFFF, fault: 1'b1};
        vecs[2] = '{word: 16'h0C83, fault: 1'b1};
        vecs[3] = '{word: 16'h0C9F, fault: 1'b0};
        vecs[4] = '{word: 16'h001C, fault: 1'b0};
        vecs[5] = '{word: 16'hFFE3, fault: 1'b1};
        vecs[6] = '{word: 16'h0000, fault: 1'b1};

        step();
        step();
        chk("reset.cs_n", 32'(cs_n), 32'd1);
        chk("reset.sck", 32'(sck), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.sample", 32'(sample), 32'd0);
        chk("reset.valid", 32'(sample_valid), 32'd0);
        chk("reset.fault", 32'(sensor_fault), 32'd0);
        chk("reset.dropped", 32'(req_dropped), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 7; i++) begin
            do_read($sformatf("vec%0d", i), vecs[i].word, vecs[i].fault);
        end

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w = w | 16'h001C;
            do_read($sformatf("rand%0d", i), w, ref_fault(w));
        end

        // Periodic mode: falls exactly Interval apart, busy drops in between.
        sensor_word = 16'h0C9F;
        f0 = cs_falls;
        auto_en = 1'b1;
        wait_valid(valid_cnt, 0);
        for (int k = 0; k < 400 && cs_falls < f0 + 1; k++) step();
        t1 = fall_cyc;
        b0 = busy_low_cnt;
        for (int k = 0; k < 400 && cs_falls < f0 + 2; k++) step();
        t2 = fall_cyc;
        chk("periodic.busy_low_between", 32'((busy_low_cnt - b0) > 0), 32'd1);
        for (int k = 0; k < 400 && cs_falls < f0 + 3; k++) step();
        t3 = fall_cyc;
        chk("periodic.interval1", 32'(t2 - t1), 32'(Interval));
        chk("periodic.interval2", 32'(t3 - t2), 32'(Interval));

        // start_req on the wrap edge merges with the auto request.
        f0 = cs_falls;
        d0 = dropped_cnt;
        repeat (199) step();
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        auto_en = 1'b0;
        repeat (250) step();
        chk("collide_wrap.falls", 32'(cs_falls - f0), 32'd1);
        chk("collide_wrap.dropped", 32'(dropped_cnt - d0), 32'd0);

        // Two requests during SHIFT: one follow-up, one drop.
        sensor_word = 16'h0C9F;
        f0 = cs_falls;
        v0 = valid_cnt;
        d0 = dropped_cnt;
        pulse_start();
        wait_rises(f0, 3, 100);
        pulse_start();
        repeat (4) step();
        pulse_start();
        wait_valid(v0 + 2, 400);
        chk("two_req.valids", 32'(valid_cnt - v0), 32'd2);
        chk("two_req.dropped", 32'(dropped_cnt - d0), 32'd1);
        chk("two_req.falls", 32'(cs_falls - f0), 32'd2);
        chk("two_req.gap", 32'(last_high_len), 32'(MinGap + 1));
        chk("two_req.sample", 32'(sample), 32'h0C9F);
        repeat (80) step();
        chk("two_req.no_extra", 32'(cs_falls - f0), 32'd2);

        // Asynchronous reset in the middle of SHIFT.
        sensor_word = 16'h0C9F;
        f0 = cs_falls;
        pulse_start();
        wait_rises(f0, 8, 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.cs_n", 32'(cs_n), 32'd1);
        chk("midreset.sck", 32'(sck), 32'd0);
        chk("midreset.busy", 32'(busy), 32'd0);
        chk("midreset.sample", 32'(sample), 32'd0);
        chk("midreset.valid", 32'(sample_valid), 32'd0);
        chk("midreset.fault", 32'(sensor_fault), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        do_read("post_reset", 16'h1A5F, 1'b0);

        // ena gating: request is retained while disabled.
        sensor_word = 16'h0C9F;
        ena = 1'b0;
        f0 = cs_falls;
        v0 = valid_cnt;
        pulse_start();
        repeat (20) step();
        chk("ena_off.no_activity", 32'(cs_falls - f0), 32'd0);
        ena = 1'b1;
        step();
        chk("ena_on.cs_n", 32'(cs_n), 32'd0);
        chk("ena_on.falls", 32'(cs_falls - f0), 32'd1);
        wait_rises(f0, 5, 100);
        ena = 1'b0;
        wait_valid(v0 + 1, 150);
        chk("ena_drop.valid", 32'(valid_cnt - v0), 32'd1);
        chk("ena_drop.sample", 32'(sample), 32'h0C9F);
        chk("ena_drop.sck_rises", 32'(sck_rises), 32'd16);
        repeat (60) step();
        chk("ena_drop.no_extra", 32'(cs_falls - f0), 32'd1);
        ena = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
